// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Multi-channel push-button conditioner for the game board inputs
//   (flap, start, pause). Each channel has:
//     * a 2-FF synchroniser on the raw pin
//     * a saturating stability counter and a 4-state FSM
//       (LO_STABLE, LO_WAIT, HI_STABLE, HI_WAIT)
//     * a registered clean level and 1-cycle press/release pulses
//   The FSM state of each channel is held in g_ch[i].state_q so that it
//   can be probed hierarchically.
//
//   Optional feature macro: DEBOUNCE_AUTOREPEAT_EN
//     defined   -> per-channel repeat timer; btn_rep pulses REPEAT_DLY cycles
//                  after the press, then every REPEAT_PER cycles while held
//     undefined -> btn_rep tied to 0, no timer logic
//
// Ports
//   clk      in   1     system clock, rising edge
//   reset    in   1     asynchronous, active-high, clears all state
//   btn_raw  in   N_CH  raw asynchronous button pins, 1 = pressed
//   btn_lvl  out  N_CH  debounced level, registered
//   btn_rise out  N_CH  1-cycle pulse when btn_lvl goes 0->1
//   btn_fall out  N_CH  1-cycle pulse when btn_lvl goes 1->0
//   btn_rep  out  N_CH  1-cycle auto-repeat pulse (0 without the macro)
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int N_CH       = 2,
   parameter int CNT_W      = 20,
   parameter int STABLE_CNT = 1000000,
   parameter int REPEAT_DLY = 50000000,
   parameter int REPEAT_PER = 10000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_lvl,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_rep
);

   typedef enum logic [1:0] {
      LO_STABLE = 2'd0,
      LO_WAIT   = 2'd1,
      HI_STABLE = 2'd2,
      HI_WAIT   = 2'd3
   } state_t;

   // Elaboration-time parameter sanity checks.
   if (STABLE_CNT < 2) begin : g_bad_stable
      $error("STABLE_CNT must be >= 2");
   end
   if ((64'd1 << CNT_W) <= 64'(STABLE_CNT)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for STABLE_CNT");
   end
   if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_repeat
      $error("REPEAT_DLY and REPEAT_PER must be >= 1");
   end

   // Two-flop synchroniser; only s_q is seen by the FSMs.
   logic [N_CH-1:0] s1_q, s1_d;
   logic [N_CH-1:0] s_q, s_d;

   always_comb begin
      s1_d = btn_raw;
      s_d  = s1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         s_q  <= '0;
      end else begin
         s1_q <= s1_d;
         s_q  <= s_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;
      logic             rise_q, rise_d;
      logic             fall_q, fall_d;

      // Next-state logic. The counter counts consecutive cycles the
      // synchronised input has disagreed with the accepted level and is
      // cleared on every state change, so it never wraps.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         case (state_q)
            LO_STABLE: begin
               if (s_q[g]) begin
                  state_d = LO_WAIT;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d   = '0;
               end
            end
            LO_WAIT: begin
               if (!s_q[g]) begin
                  state_d = LO_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
                  state_d = HI_STABLE;
                  lvl_d   = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            HI_STABLE: begin
               if (!s_q[g]) begin
                  state_d = HI_WAIT;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d   = '0;
               end
            end
            HI_WAIT: begin
               if (s_q[g]) begin
                  state_d = HI_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
                  state_d = LO_STABLE;
                  lvl_d   = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = LO_STABLE;
               cnt_d   = '0;
               lvl_d   = 1'b0;
            end
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      assign btn_lvl[g]  = lvl_q;
      assign btn_rise[g] = rise_q;
      assign btn_fall[g] = fall_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
      localparam int TMR_W = CNT_W + 6;

      logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
      logic             armed_q, armed_d;
      logic             rep_q, rep_d;

      // Timer counts cycles spent in the high states. The first period is
      // REPEAT_DLY; once armed, each further period is REPEAT_PER. The timer
      // restarts from 0 after every pulse, so it stays bounded. It is held
      // at 0 on the rise edge and on the fall edge, so a repeat pulse never
      // shares a cycle with either.
      always_comb begin
         tmr_d   = tmr_q;
         armed_d = armed_q;
         rep_d   = 1'b0;
         tmr_inc = tmr_q + TMR_W'(1);
         if (rise_d || fall_d || !(state_q == HI_STABLE || state_q == HI_WAIT)) begin
            tmr_d   = '0;
            armed_d = 1'b0;
         end else if (!armed_q && tmr_inc == TMR_W'(REPEAT_DLY)) begin
            rep_d   = 1'b1;
            tmr_d   = '0;
            armed_d = 1'b1;
         end else if (armed_q && tmr_inc == TMR_W'(REPEAT_PER)) begin
            rep_d   = 1'b1;
            tmr_d   = '0;
         end else begin
            tmr_d   = tmr_inc;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            tmr_q   <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
         end else begin
            tmr_q   <= tmr_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
         end
      end

      assign btn_rep[g] = rep_q;
`else
      assign btn_rep[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer (N_CH=2, STABLE_CNT=4, REPEAT_DLY=20,
//   REPEAT_PER=8). A behavioural model tracks, per channel, how many
//   consecutive cycles the synchronised input has disagreed with the accepted
//   level, and how long the level has been held high. The model result is
//   queued each clock and compared against the DUT on every falling edge;
//   literal expectations at key points pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   localparam int N_CH       = 2;
   localparam int CNT_W      = 4;
   localparam int STABLE_CNT = 4;
   localparam int REPEAT_DLY = 20;
   localparam int REPEAT_PER = 8;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] btn_lvl, btn_rise, btn_fall, btn_rep;

   always #5 clk = ~clk;

   button_debouncer #(
      .N_CH      (N_CH),
      .CNT_W     (CNT_W),
      .STABLE_CNT(STABLE_CNT),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw),
      .btn_lvl (btn_lvl),
      .btn_rise(btn_rise),
      .btn_fall(btn_fall),
      .btn_rep (btn_rep)
   );

   int   checks = 0;
   int   errors = 0;
   logic cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N_CH-1:0] m_s1 = '0, m_s = '0;
   logic [N_CH-1:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_rep = '0;
   int              m_run  [N_CH];
   int              m_held [N_CH];
   logic [4*N_CH-1:0] exp_q[$];

   initial begin
      logic [N_CH-1:0] s_seen;
      logic            old_lvl;
      for (int c = 0; c < N_CH; c++) begin
         m_run[c]  = 0;
         m_held[c] = 0;
      end
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_s1 = '0; m_s = '0; m_lvl = '0;
            m_rise = '0; m_fall = '0; m_rep = '0;
            for (int c = 0; c < N_CH; c++) begin
               m_run[c]  = 0;
               m_held[c] = 0;
            end
         end else begin
            s_seen = m_s;
            m_s    = m_s1;
            m_s1   = btn_raw;
            m_rise = '0; m_fall = '0; m_rep = '0;
            for (int c = 0; c < N_CH; c++) begin
               old_lvl = m_lvl[c];
               if (s_seen[c] != old_lvl) m_run[c]++;
               else                      m_run[c] = 0;
               if (m_run[c] == STABLE_CNT) begin
                  m_lvl[c] = ~old_lvl;
                  m_run[c] = 0;
                  if (!old_lvl) m_rise[c] = 1'b1;
                  else          m_fall[c] = 1'b1;
               end
`ifdef DEBOUNCE_AUTOREPEAT_EN
               if (m_rise[c]) begin
                  m_held[c] = 0;
               end else if (old_lvl && !m_fall[c]) begin
                  m_held[c]++;
                  if (m_held[c] == REPEAT_DLY ||
                      (m_held[c] > REPEAT_DLY && (m_held[c] - REPEAT_DLY) % REPEAT_PER == 0))
                     m_rep[c] = 1'b1;
               end else begin
                  m_held[c] = 0;
               end
`endif
            end
         end
         exp_q.delete();
         exp_q.push_back({m_rep, m_fall, m_rise, m_lvl});
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      logic [4*N_CH-1:0] e;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exp_q_empty: no model value at %0t", $time);
            end else begin
               e = exp_q[$];
               chk("cyc_lvl",  btn_lvl,  e[N_CH-1:0]);
               chk("cyc_rise", btn_rise, e[2*N_CH-1:N_CH]);
               chk("cyc_fall", btn_fall, e[3*N_CH-1:2*N_CH]);
               chk("cyc_rep",  btn_rep,  e[4*N_CH-1:3*N_CH]);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- driver ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [N_CH-1:0] ev;
      logic            exp_rep;
      btn_raw = '0;
      reset   = 1'b1;
      wait_neg(3);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // 1. quiet after reset
      chk("t1_reset_outs", {btn_rep, btn_fall, btn_rise, btn_lvl}, 0);
      for (int i = 0; i < 20; i++) begin
         wait_neg(1);
         chk("t1_quiet", {btn_rep, btn_fall, btn_rise, btn_lvl}, 0);
      end

      // 2. ch0 press: level and rise appear 5 edges after first sample
      btn_raw = 2'b01;
      wait_neg(5);
      chk("t2_lvl_before", btn_lvl, 2'b00);
      chk("t2_lvl_before_model", m_lvl, 2'b00);
      wait_neg(1);
      chk("t2_lvl", btn_lvl, 2'b01);
      chk("t2_rise", btn_rise, 2'b01);
      chk("t2_rise_model", m_rise, 2'b01);
      wait_neg(1);
      chk("t2_rise_end", btn_rise, 2'b00);
      chk("t2_lvl_hold", btn_lvl, 2'b01);
      btn_raw = 2'b00;
      wait_neg(6);
      chk("t2_fall", btn_fall, 2'b01);
      chk("t2_fall_lvl", btn_lvl, 2'b00);
      wait_neg(4);

      // 3. bounce shorter than the stability window
      ev = '0;
      for (int i = 0; i < 5; i++) begin
         btn_raw[0] = (i == 0 || i == 2 || i == 3);
         wait_neg(1);
         ev |= btn_rise | btn_fall | btn_lvl;
      end
      btn_raw = 2'b00;
      for (int i = 0; i < 10; i++) begin
         wait_neg(1);
         ev |= btn_rise | btn_fall | btn_lvl;
      end
      chk("t3_no_events", ev, 2'b00);
      chk("t3_model_lvl", m_lvl, 2'b00);

      // 4. both channels together
      btn_raw = 2'b11;
      wait_neg(6);
      chk("t4_rise", btn_rise, 2'b11);
      chk("t4_lvl", btn_lvl, 2'b11);
      wait_neg(24);
      btn_raw = 2'b00;
      wait_neg(5);
      chk("t4_fall_early", btn_fall, 2'b00);
      wait_neg(1);
      chk("t4_fall", btn_fall, 2'b11);
      chk("t4_fall_model", m_fall, 2'b11);
      chk("t4_lvl_low", btn_lvl, 2'b00);
      wait_neg(4);

      // 5. reset mid-wait on ch1 while ch0 is high
      btn_raw = 2'b01;
      wait_neg(8);
      chk("t5_ch0_high", btn_lvl, 2'b01);
      btn_raw = 2'b11;
      wait_neg(4);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_clear", {btn_rep, btn_fall, btn_rise, btn_lvl}, 0);
      chk("t5_model_clear", m_lvl, 2'b00);
      wait_neg(3);
      reset = 1'b0;
      wait_neg(5);
      chk("t5_fresh_wait", btn_lvl, 2'b00);
      wait_neg(1);
      chk("t5_lvl_after", btn_lvl, 2'b11);
      chk("t5_rise_after", btn_rise, 2'b11);
      btn_raw = 2'b00;
      wait_neg(10);

      // 6. ch0 held 50 cycles after rise; repeat pulses only with the macro
      btn_raw = 2'b01;
      wait_neg(6);
      chk("t6_rise", btn_rise, 2'b01);
      for (int i = 1; i <= 60; i++) begin
         wait_neg(1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
         exp_rep = (i == 20 || i == 28 || i == 36 || i == 44);
`else
         exp_rep = 1'b0;
`endif
         chk("t6_rep", btn_rep, {1'b0, exp_rep});
         if (i == 50) chk("t6_fall", btn_fall, 2'b01);
         if (i == 44) btn_raw = 2'b00;
      end
      chk("t6_lvl_end", btn_lvl, 2'b00);

      // random segments, checked by the model every cycle
      for (int i = 0; i < 40; i++) begin
         btn_raw = N_CH'($urandom_range(0, 3));
         wait_neg($urandom_range(1, 8));
      end
      btn_raw = 2'b00;
      wait_neg(20);
      chk("end_lvl", btn_lvl, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
